// File: rtl/sevenseg_pkg.sv
// Shared constants and types for the seven-segment display reader.
// Segment bit order is abc_defg: bit 6 = a, bit 0 = g.
package sevenseg_pkg;

  localparam logic [6:0] SEG_0 = 7'b1111110;
  localparam logic [6:0] SEG_1 = 7'b0110000;
  localparam logic [6:0] SEG_2 = 7'b1101101;
  localparam logic [6:0] SEG_3 = 7'b1111001;
  localparam logic [6:0] SEG_4 = 7'b0110011;
  localparam logic [6:0] SEG_5 = 7'b1011011;
  localparam logic [6:0] SEG_6 = 7'b1011111;
  localparam logic [6:0] SEG_7 = 7'b1110000;
  localparam logic [6:0] SEG_8 = 7'b1111111;
  localparam logic [6:0] SEG_9 = 7'b1111011;
  localparam logic [6:0] SEG_OFF = 7'b0000000;

  localparam logic [3:0] CODE_BLANK   = 4'hE;
  localparam logic [3:0] CODE_INVALID = 4'hF;

  typedef enum logic {
    COLLECT,
    HOLD
  } state_e;

endpackage

// File: rtl/sevenseg_reader_if.sv
// Observed display lines in, decoded frame out with a valid/ready handshake.
// The reader is the slave side; the environment driving the lines is master.
interface sevenseg_reader_if;
  logic [6:0]  segments;
  logic [3:0]  digit_sel;
  logic        frame_ready;
  logic        frame_valid;
  logic [15:0] digits;
  logic [3:0]  err;

  modport slave (
    input  segments,
    input  digit_sel,
    input  frame_ready,
    output frame_valid,
    output digits,
    output err
  );

  modport master (
    output segments,
    output digit_sel,
    output frame_ready,
    input  frame_valid,
    input  digits,
    input  err
  );
endinterface

// File: rtl/sevenseg_pattern_decode.sv
// Maps a segment pattern to a digit code; unknown patterns flag err.
// An all-off pattern is a legal blank digit.
module sevenseg_pattern_decode
  import sevenseg_pkg::*;
(
  input  logic [6:0] segments,
  output logic [3:0] code,
  output logic       err
);

  always_comb begin
    code = CODE_INVALID;
    err  = 1'b1;
    case (segments)
      SEG_0:   begin code = 4'd0; err = 1'b0; end
      SEG_1:   begin code = 4'd1; err = 1'b0; end
      SEG_2:   begin code = 4'd2; err = 1'b0; end
      SEG_3:   begin code = 4'd3; err = 1'b0; end
      SEG_4:   begin code = 4'd4; err = 1'b0; end
      SEG_5:   begin code = 4'd5; err = 1'b0; end
      SEG_6:   begin code = 4'd6; err = 1'b0; end
      SEG_7:   begin code = 4'd7; err = 1'b0; end
      SEG_8:   begin code = 4'd8; err = 1'b0; end
      SEG_9:   begin code = 4'd9; err = 1'b0; end
      SEG_OFF: begin code = CODE_BLANK; err = 1'b0; end
      default: begin code = CODE_INVALID; err = 1'b1; end
    endcase
  end

endmodule

// File: rtl/sevenseg_reader.sv
// Debounces multiplexed seven-segment lines into a 4-digit frame and
// holds it on a valid/ready handshake until the consumer accepts it.
module sevenseg_reader
  import sevenseg_pkg::*;
#(
  parameter int STABLE = 4
) (
  input  logic             clk,
  input  logic             reset,
  sevenseg_reader_if.slave bus
);

  localparam int LW = $clog2(STABLE + 1);
  localparam logic [LW-1:0] L_MAX = LW'(STABLE);
  localparam logic [LW-1:0] L_ONE = LW'(1);

  state_e      state_q, state_d;
  logic [10:0] prev_q, prev_d;
  logic [LW-1:0] len_q, len_d;
  logic [3:0]  mask_q, mask_d;
  logic [15:0] shadow_q, shadow_d;
  logic [3:0]  shadow_err_q, shadow_err_d;
  logic [15:0] digits_q, digits_d;
  logic [3:0]  err_q, err_d;

  logic [10:0] cur;
  logic        onehot;
  logic        capture;
  logic [1:0]  pos;
  logic [3:0]  dec_code;
  logic        dec_err;

  sevenseg_pattern_decode u_decode (
    .segments (bus.segments),
    .code     (dec_code),
    .err      (dec_err)
  );

  assign cur    = {bus.digit_sel, bus.segments};
  assign onehot = $onehot(bus.digit_sel);

  // Saturating at STABLE makes the capture fire once per run.
  always_comb begin
    prev_d = cur;
    len_d  = '0;
    if (onehot) begin
      if (len_q != '0 && cur == prev_q)
        len_d = (len_q == L_MAX) ? L_MAX : len_q + L_ONE;
      else
        len_d = L_ONE;
    end
    capture = (len_d == L_MAX) && (len_q != L_MAX);
  end

  always_comb begin
    pos = 2'd0;
    unique case (bus.digit_sel)
      4'b0001: pos = 2'd0;
      4'b0010: pos = 2'd1;
      4'b0100: pos = 2'd2;
      4'b1000: pos = 2'd3;
      default: pos = 2'd0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    shadow_d     = shadow_q;
    shadow_err_d = shadow_err_q;
    digits_d     = digits_q;
    err_d        = err_q;
    case (state_q)
      COLLECT: begin
        if (capture) begin
          shadow_d[4*pos +: 4] = dec_code;
          shadow_err_d[pos]    = dec_err;
          mask_d[pos]          = 1'b1;
          if (mask_d == 4'hF) begin
            state_d  = HOLD;
            digits_d = shadow_d;
            err_d    = shadow_err_d;
          end
        end
      end
      HOLD: begin
        if (bus.frame_ready) begin
          state_d = COLLECT;
          mask_d  = '0;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= COLLECT;
      prev_q       <= '0;
      len_q        <= '0;
      mask_q       <= '0;
      shadow_q     <= {4{CODE_BLANK}};
      shadow_err_q <= '0;
      digits_q     <= {4{CODE_BLANK}};
      err_q        <= '0;
    end else begin
      state_q      <= state_d;
      prev_q       <= prev_d;
      len_q        <= len_d;
      mask_q       <= mask_d;
      shadow_q     <= shadow_d;
      shadow_err_q <= shadow_err_d;
      digits_q     <= digits_d;
      err_q        <= err_d;
    end
  end

  assign bus.frame_valid = (state_q == HOLD);
  assign bus.digits      = digits_q;
  assign bus.err         = err_q;

endmodule

// File: tb/tb_sevenseg_reader.sv
// Directed and random stimulus for sevenseg_reader against a
// cycle-level frame model built from the display's observable rules.
module tb_sevenseg_reader;

  localparam int STABLE = 4;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sevenseg_reader_if bus ();

  sevenseg_reader #(.STABLE(STABLE)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [6:0] pats [10] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
    7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011
  };

  int          run;
  logic [10:0] prev;
  bit          hold;
  logic [3:0]  sc [4];
  bit          se [4];
  logic [3:0]  mask;
  logic [15:0] md;
  logic [3:0]  me;

  task automatic chk(string tag, logic [15:0] got, logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h want=%h", tag, got, exp);
    end
  endtask

  function automatic logic [4:0] ref_decode(logic [6:0] s);
    for (int i = 0; i < 10; i++)
      if (s == pats[i]) return {1'b0, 4'(i)};
    if (s == 7'd0) return {1'b0, 4'hE};
    return {1'b1, 4'hF};
  endfunction

  task automatic model_step();
    int old;
    int p;
    bit cap;
    logic [10:0] cur;
    logic [4:0] d;
    if (reset) begin
      run = 0; hold = 0; mask = 0;
      md = 16'hEEEE; me = 4'h0;
      for (int i = 0; i < 4; i++) begin sc[i] = 4'hE; se[i] = 0; end
    end else begin
      old = run;
      cur = {bus.digit_sel, bus.segments};
      if ($countones(bus.digit_sel) != 1) run = 0;
      else if (run > 0 && cur == prev) run = (run < STABLE) ? run + 1 : STABLE;
      else run = 1;
      prev = cur;
      cap = (run == STABLE) && (old < STABLE);
      if (hold) begin
        if (bus.frame_ready) begin hold = 0; mask = 0; end
      end else if (cap) begin
        p = 0;
        for (int i = 0; i < 4; i++) if (bus.digit_sel[i]) p = i;
        d = ref_decode(bus.segments);
        sc[p] = d[3:0];
        se[p] = d[4];
        mask[p] = 1'b1;
        if (mask == 4'hF) begin
          hold = 1;
          md = {sc[3], sc[2], sc[1], sc[0]};
          me = {se[3], se[2], se[1], se[0]};
        end
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
    chk("valid", 16'(bus.frame_valid), 16'(hold));
    chk("digits", bus.digits, md);
    chk("err", 16'(bus.err), 16'(me));
  endtask

  task automatic drive(logic [3:0] sel, logic [6:0] seg, logic rdy, int n);
    bus.digit_sel   = sel;
    bus.segments    = seg;
    bus.frame_ready = rdy;
    repeat (n) cyc();
  endtask

  initial begin
    logic [3:0] rs;
    logic [6:0] rg;
    reset = 1'b1;
    bus.digit_sel = 4'h0;
    bus.segments = 7'h0;
    bus.frame_ready = 1'b0;
    repeat (2) cyc();
    reset = 1'b0;
    chk("rst_valid", 16'(bus.frame_valid), 16'h0);
    chk("rst_digits", bus.digits, 16'hEEEE);
    chk("rst_err", 16'(bus.err), 16'h0);

    // basic frame
    for (int d = 0; d < 4; d++) drive(4'(1 << d), pats[d+1], 1'b1, 4);
    chk("basic_valid", 16'(bus.frame_valid), 16'h1);
    chk("basic_digits", bus.digits, 16'h4321);
    chk("basic_err", 16'(bus.err), 16'h0);
    drive(4'h0, 7'h0, 1'b1, 1);
    chk("basic_drop", 16'(bus.frame_valid), 16'h0);
    chk("basic_keep", bus.digits, 16'h4321);

    // short run must not capture
    drive(4'h1, pats[0], 1'b1, 3);
    drive(4'h2, pats[5], 1'b1, 4);
    drive(4'h4, pats[6], 1'b1, 4);
    drive(4'h8, pats[7], 1'b1, 4);
    chk("short_nocap", 16'(bus.frame_valid), 16'h0);
    drive(4'h1, pats[0], 1'b0, 20);
    chk("long_valid", 16'(bus.frame_valid), 16'h1);
    chk("long_digits", bus.digits, 16'h7650);
    drive(4'h0, 7'h0, 1'b1, 1);

    // invalid pattern on digit 2
    drive(4'h1, pats[9], 1'b1, 4);
    drive(4'h2, pats[8], 1'b1, 4);
    drive(4'h4, 7'b1000000, 1'b0, 4);
    drive(4'h8, pats[2], 1'b0, 4);
    chk("inv_digits", bus.digits, 16'h2F89);
    chk("inv_err", 16'(bus.err), 16'h4);
    drive(4'h8, pats[2], 1'b1, 1);

    // backpressure in HOLD
    drive(4'h1, pats[1], 1'b0, 4);
    drive(4'h2, pats[2], 1'b0, 4);
    drive(4'h4, pats[3], 1'b0, 4);
    drive(4'h8, pats[4], 1'b0, 4);
    drive(4'h1, pats[5], 1'b0, 5);
    drive(4'h2, pats[6], 1'b0, 5);
    chk("bp_valid", 16'(bus.frame_valid), 16'h1);
    chk("bp_digits", bus.digits, 16'h4321);
    drive(4'h4, pats[7], 1'b1, 4);
    drive(4'h8, pats[8], 1'b1, 4);
    drive(4'h1, pats[9], 1'b0, 4);
    drive(4'h2, pats[0], 1'b0, 4);
    chk("bp_next", bus.digits, 16'h8709);
    drive(4'h0, 7'h0, 1'b1, 1);

    // non-one-hot select and glitch restart
    drive(4'h1, pats[3], 1'b0, 4);
    drive(4'h2, pats[3], 1'b0, 4);
    drive(4'h4, pats[3], 1'b0, 4);
    drive(4'b0011, pats[1], 1'b0, 6);
    drive(4'h8, pats[1], 1'b0, 2);
    drive(4'h8, pats[2], 1'b0, 1);
    drive(4'h8, pats[1], 1'b0, 3);
    chk("glitch_wait", 16'(bus.frame_valid), 16'h0);
    drive(4'h8, pats[1], 1'b0, 1);
    chk("glitch_valid", 16'(bus.frame_valid), 16'h1);
    chk("glitch_digits", bus.digits, 16'h1333);
    drive(4'h0, 7'h0, 1'b1, 1);

    // reset with partial mask, then in HOLD
    drive(4'h1, pats[1], 1'b1, 4);
    drive(4'h2, pats[2], 1'b1, 4);
    drive(4'h4, pats[3], 1'b1, 4);
    reset = 1'b1;
    drive(4'h8, pats[4], 1'b1, 1);
    reset = 1'b0;
    chk("rstp_valid", 16'(bus.frame_valid), 16'h0);
    chk("rstp_digits", bus.digits, 16'hEEEE);
    drive(4'h8, pats[4], 1'b0, 4);
    chk("rstp_recollect", 16'(bus.frame_valid), 16'h0);
    drive(4'h1, pats[1], 1'b0, 4);
    drive(4'h2, pats[2], 1'b0, 4);
    drive(4'h4, pats[3], 1'b0, 4);
    chk("rstp_full", bus.digits, 16'h4321);
    reset = 1'b1;
    drive(4'h1, pats[5], 1'b0, 1);
    reset = 1'b0;
    chk("rsth_valid", 16'(bus.frame_valid), 16'h0);
    chk("rsth_digits", bus.digits, 16'hEEEE);
    chk("rsth_err", 16'(bus.err), 16'h0);

    // random traffic
    for (int k = 0; k < 600; k++) begin
      if ($urandom_range(0, 9) < 8) rs = 4'(1 << $urandom_range(0, 3));
      else rs = 4'($urandom);
      case ($urandom_range(0, 9))
        0:       rg = 7'h0;
        1, 2:    rg = 7'($urandom);
        default: rg = pats[$urandom_range(0, 9)];
      endcase
      reset = ($urandom_range(0, 99) == 0);
      drive(rs, rg, 1'($urandom), $urandom_range(1, 7));
    end
    reset = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
